// File: rtl/exibe_sequencia.sv
// rtl/exibe_sequencia.sv - memory-game sequence presenter driving the player LEDs from the sync ROM
// Optional end-of-sequence blink enabled by defining PISCA_FIM_EN.
module exibe_sequencia #(
    parameter int TEMPO_ACESO   = 1000,
    parameter int TEMPO_APAGADO = 500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] limite,
    input  logic [3:0] dado,
    output logic [3:0] endereco,
    output logic [3:0] leds,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);

    localparam int TMAX = (TEMPO_ACESO > TEMPO_APAGADO) ? TEMPO_ACESO : TEMPO_APAGADO;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [3:0] {
        INICIAL = 4'd0,
        PREPARA = 4'd1,
        LE      = 4'd2,
        CARREGA = 4'd3,
        ACESO   = 4'd4,
        APAGADO = 4'd5,
        PROXIMO = 4'd6,
        PISCA   = 4'd7,
        FIM     = 4'd8
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [3:0]    endereco_q, endereco_d;
    logic [3:0]    item_q, item_d;
    logic [3:0]    lim_q, lim_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [TW-1:0] timer_inc;

    // Timer holds at its terminal count instead of wrapping.
    assign timer_inc = (timer_q == TW'(TMAX)) ? timer_q : timer_q + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= INICIAL;
            endereco_q <= 4'd0;
            item_q     <= 4'd0;
            lim_q      <= 4'd0;
            timer_q    <= '0;
        end else begin
            estado_q   <= estado_d;
            endereco_q <= endereco_d;
            item_q     <= item_d;
            lim_q      <= lim_d;
            timer_q    <= timer_d;
        end
    end

    always_comb begin
        estado_d   = estado_q;
        endereco_d = endereco_q;
        item_d     = item_q;
        lim_d      = lim_q;
        timer_d    = timer_q;
        case (estado_q)
            INICIAL: if (iniciar) estado_d = PREPARA;
            PREPARA: begin
                endereco_d = 4'd0;
                lim_d      = limite;
                timer_d    = '0;
                estado_d   = LE;
            end
            LE: estado_d = CARREGA;
            CARREGA: begin
                item_d   = dado;
                timer_d  = '0;
                estado_d = ACESO;
            end
            ACESO: begin
                if (timer_q == TW'(TEMPO_ACESO - 1)) begin
                    timer_d  = '0;
                    estado_d = APAGADO;
                end else begin
                    timer_d = timer_inc;
                end
            end
            APAGADO: begin
                if (timer_q == TW'(TEMPO_APAGADO - 1)) estado_d = PROXIMO;
                else                                   timer_d  = timer_inc;
            end
            PROXIMO: begin
                timer_d = '0;
                if (endereco_q == lim_q) begin
`ifdef PISCA_FIM_EN
                    estado_d = PISCA;
`else
                    estado_d = FIM;
`endif
                end else begin
                    endereco_d = endereco_q + 4'd1;
                    estado_d   = LE;
                end
            end
`ifdef PISCA_FIM_EN
            PISCA: begin
                if (timer_q == TW'(TEMPO_ACESO - 1)) estado_d = FIM;
                else                                 timer_d  = timer_inc;
            end
`endif
            FIM:     estado_d = INICIAL;
            default: estado_d = INICIAL;
        endcase
    end

    always_comb begin
        leds = 4'd0;
        case (estado_q)
            ACESO:   leds = item_q;
`ifdef PISCA_FIM_EN
            PISCA:   leds = 4'hF;
`endif
            default: leds = 4'd0;
        endcase
        ocupado = (estado_q != INICIAL);
        pronto  = (estado_q == FIM);
    end

    assign endereco  = endereco_q;
    assign db_estado = estado_q;

endmodule

// File: doc/exibe_sequencia.md
# exibe_sequencia

Sequence presenter for the memory game: on request, walks the stored 16x4 sequence from address 0 through a programmable limit and shows each item on the four player LEDs for a fixed on-time followed by a blank gap. It is the output half of the game protocol. The existing datapath receives player moves and compares them against the sequence memory; this block drives the same sequence to the player. It sits beside that datapath, shares the synchronous ROM via the address/data pair, and is commanded by the top-level control unit through an `iniciar`/`pronto` handshake.

## Interface
Parameters:
- `TEMPO_ACESO`, default 1000: cycles each item is shown on `leds`, ≥1.
- `TEMPO_APAGADO`, default 500: cycles of blank (`leds`=0) after each item, ≥1.

Ports:
- `clock` in 1: single system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high; takes priority over every other input.
- `iniciar` in 1: start request, sampled only in `inicial`.
- `limite` in 4: last address to show, inclusive; latched in `prepara`.
- `dado` in 4: ROM `data_out`; valid one cycle after `endereco` changes (sync ROM).
- `endereco` out 4: ROM address.
- `leds` out 4: player LED pattern.
- `ocupado` out 1: high in every state except `inicial`.
- `pronto` out 1: one-cycle pulse at the end of a presentation.
- `db_estado` out 4: current state encoding, for the debug display.

## Operation
- State encoding: `inicial`=0, `prepara`=1, `le`=2, `carrega`=3, `aceso`=4, `apagado`=5, `proximo`=6, `pisca`=7 (only with the macro), `fim`=8.
- `inicial`: `leds`=0, `endereco` holds its value. `iniciar`=1 → `prepara`. Otherwise the FSM stays in `inicial`.
- `prepara`: `endereco`←0; latch `limite` into `lim_r`; clear the timer. Next state is `le`.
- `le`: ROM latency cycle; `leds`=0. Next state is `carrega`.
- `carrega`: item register ←`dado`; clear the timer. Next state is `aceso`.
- `aceso`: `leds`=item register. The timer counts. After `TEMPO_ACESO` cycles in `aceso`, go to `apagado` and clear the timer.
- `apagado`: `leds`=0. The timer counts. After `TEMPO_APAGADO` cycles, go to `proximo`.
- `proximo`: if `endereco`==`lim_r`, go to `pisca` (macro defined) or `fim`. Otherwise `endereco`←`endereco`+1 and go to `le`.
- `fim`: `pronto`=1 for this single cycle; `leds`=0. Next state is `inicial`.
- Boundary conditions:
  - `iniciar` is ignored while `ocupado`=1.
  - Changes to `limite` after `prepara` have no effect.
  - `limite`=0 shows exactly one item.
  - `limite`=15 shows 16 items; `endereco` never increments past 15 (no wrap).
  - A `dado` value of 0 is shown as an all-off `aceso` period, with the same timing as any other item.
- Width rules:
  - The timer is `$clog2(max(TEMPO_ACESO,TEMPO_APAGADO)+1)` bits and saturates at its terminal count.
  - Address arithmetic is 4-bit unsigned.

## Timing
- Reset values: state `inicial`, `endereco`=0, `leds`=0, item register 0, `lim_r`=0, timer 0, `ocupado`=0, `pronto`=0, `db_estado`=0.
- Reset mid-presentation returns to `inicial` on the next edge with all of the reset values above; no `pronto` pulse is produced.
- Cycle numbering: the cycle spent in `prepara` is cycle 1.
- Per-item cost is `TEMPO_ACESO`+`TEMPO_APAGADO`+3 cycles (`le`, `carrega`, `proximo`).
- Without the macro, `pronto` is high in cycle 1 + (`limite`+1)·(`TEMPO_ACESO`+`TEMPO_APAGADO`+3) + 1.
- With the macro, `pronto` is high `TEMPO_ACESO` cycles later than the figure above.
- All outputs are registered or decoded from registered state only; there is no combinational path from any input to any output.

## Configuration
- Macro: `PISCA_FIM_EN`.
- Defined: after the last item, `proximo` goes to `pisca`. In `pisca`, `leds`=4'hF for `TEMPO_ACESO` cycles, then the FSM goes to `fim`. This signals the end of the sequence to the player.
- Undefined: `pisca` is not synthesised and `proximo` goes directly to `fim`. Encoding 7 is unused; if it is ever reached, the FSM returns to `inicial`.

## Test plan
Unless stated, all scenarios use `TEMPO_ACESO`=4, `TEMPO_APAGADO`=2, macro undefined, and ROM preloaded with addresses 0..3 = 1,2,4,8.
- Reset, then `iniciar` with `limite`=0 → `leds`=1 in cycles 4–7; `leds`=0 in cycles 8–9; `pronto` pulses in cycle 11; `ocupado` is high in cycles 1–11.
- `limite`=3 → `leds` sequence 1,2,4,8, each item 4 cycles on and 2 off; `endereco` steps 0→3; `pronto` in cycle 38.
- `limite`=15 with ROM holding 15−addr → 16 items shown; `endereco` ends at 15 with no wrap; `pronto` in cycle 146.
- `iniciar` pulsed during `aceso`, and `limite` changed mid-run → no restart; item count matches the latched `limite`.
- `reset` asserted in cycle 20 of a `limite`=3 run → next cycle shows `db_estado`=0, `leds`=0, `endereco`=0, with no `pronto`. A following `iniciar` runs a full, correct sequence.
- Macro defined, `limite`=0 → `leds`=4'hF in cycles 11–14; `pronto` in cycle 15.
